irq_pending_dispatch: RTL

//  Receiving end of the CPU interrupt lines. The request side ORs device lines onto Irq_In.

---
 rtl/irq_pending_dispatch.sv | 138 +++++++++++++
 1 files changed

// File: rtl/irq_pending_dispatch.sv
// Interrupt pending/dispatch controller: latches rising edges of the CPU
// interrupt lines, picks the lowest-index enabled pending source and offers
// its ID to the core over a Req/Ack handshake, then waits for end-of-service.
//
// Ports:
//   Clock        - single system clock, rising edge
//   Reset_n      - asynchronous active-low reset
//   Irq_In       - raw interrupt lines (synchronous to Clock)
//   Enable_Mask  - per-source dispatch enable (1 = enabled)
//   Irq_Ack      - core accepts the offered interrupt (1-cycle pulse)
//   Irq_Done     - core finished the handler / eret (1-cycle pulse)
//   Irq_Req      - interrupt offered to the core
//   Irq_Id       - index of the offered source, valid while Irq_Req=1
//   Pending      - pending register, for debug/CSR read
//   Busy         - handler in progress
//
// Latency: a rise sampled at edge k shows in Pending after edge k and, when
// enabled and idle, raises Irq_Req after edge k+1.

module irq_pending_dispatch #(
  parameter int unsigned NrOfBits = 8,
  parameter int unsigned IdBits   = 3
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [NrOfBits-1:0] Irq_In,
  input  logic [NrOfBits-1:0] Enable_Mask,
  input  logic                Irq_Ack,
  input  logic                Irq_Done,
  output logic                Irq_Req,
  output logic [IdBits-1:0]   Irq_Id,
  output logic [NrOfBits-1:0] Pending,
  output logic                Busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NrOfBits-1:0] in_d_q;
  logic [NrOfBits-1:0] pending_q, pending_d;
  logic [IdBits-1:0]   id_q, id_d;

  logic [NrOfBits-1:0] rise;
  logic [NrOfBits-1:0] clr;
  logic [NrOfBits-1:0] candidates;
  logic                any_cand;
  logic [IdBits-1:0]   winner;
  logic                ack_fire;

  // ---------------------------------------------------------------------------
  // Edge detection and pending register
  // ---------------------------------------------------------------------------
  assign rise     = Irq_In & ~in_d_q;
  assign ack_fire = (state_q == REQ) && Irq_Ack;

  // Only the source currently offered can be cleared, and only on its Ack.
  always_comb begin
    clr = '0;
    for (int i = 0; i < int'(NrOfBits); i++) begin
      clr[i] = ack_fire && (id_q == IdBits'(i));
    end
  end

  // A rise in the same cycle as the clear wins, so the new event is kept.
  assign pending_d = (pending_q & ~clr) | rise;

  // ---------------------------------------------------------------------------
  // Priority select: lowest index among enabled pending sources.
  // Masked sources still sit in Pending; the mask only gates dispatch.
  // ---------------------------------------------------------------------------
  assign candidates = pending_q & Enable_Mask;
  assign any_cand   = |candidates;

  always_comb begin
    winner = '0;
    // Scan high to low so the lowest set index is written last.
    for (int i = int'(NrOfBits) - 1; i >= 0; i--) begin
      if (candidates[i]) begin
        winner = IdBits'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Dispatch FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (any_cand) begin
          id_d    = winner;
          state_d = REQ;
        end
      end
      REQ: begin
        // Irq_Id is frozen here regardless of Pending/Enable_Mask changes.
        if (Irq_Ack) begin
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (Irq_Done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      in_d_q    <= '0;
      pending_q <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      in_d_q    <= Irq_In;
      pending_q <= pending_d;
      id_q      <= id_d;
    end
  end

  // Outputs decode directly from flops, so they are glitch-free registers.
  assign Irq_Req = (state_q == REQ);
  assign Busy    = (state_q == SERVICE);
  assign Irq_Id  = id_q;
  assign Pending = pending_q;

endmodule
